// File: rtl/cdc_fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO read and write controllers.
// Gray conversions work on a wide vector; callers zero-extend and cast back to pointer width.
package cdc_fifo_pkg;

   localparam int ADDR_W_DEFAULT = 3;
   localparam int PTR_MAX_W      = 32;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1'b1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at and above it.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the clk domain.
// Shared by both FIFO controllers; only one bit of the bus may change per source update.
module cdc_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sync_q [STAGES];

   // Synchronizer shift chain; the first flop is the only reader of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sync_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_fifo_rd_ctrl.sv
// Read-side pointer and flag controller of an asynchronous FIFO.
// Define CDC_FIFO_ALMOST_EMPTY_EN to build in the almost_empty flag and its AE_THRESH parameter.
module cdc_fifo_rd_ctrl
   import cdc_fifo_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter int SYNC_STAGES = 2
`ifdef CDC_FIFO_ALMOST_EMPTY_EN
   ,
   parameter int AE_THRESH   = 2
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W:0]   wptr_gray,
   input  logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [ADDR_W:0]   rptr_gray,
   output logic              empty,
   output logic [ADDR_W:0]   level,
   output logic              underflow
`ifdef CDC_FIFO_ALMOST_EMPTY_EN
   ,
   output logic              almost_empty
`endif
);

   localparam int PW = ADDR_W + 1;

   logic [ADDR_W:0] wsync_gray;
   logic [ADDR_W:0] wsync_bin;
   logic [ADDR_W:0] rbin_q,      rbin_d;
   logic [ADDR_W:0] rptr_gray_q, rptr_gray_d;
   logic [ADDR_W:0] level_q,     level_d;
   logic            empty_q,     empty_d;
   logic            rd_valid_q,  rd_valid_d;
   logic            underflow_q, underflow_d;
   logic            accept;

   cdc_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_wptr_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (wptr_gray),
      .q_o   (wsync_gray)
   );

   // Next-state pointer and flags; empty and level use the post-read pointer so the last read closes the FIFO at once.
   always_comb begin
      accept      = 1'b0;
      underflow_d = underflow_q;
      if (rd_en && !empty_q) begin
         accept = 1'b1;
      end else begin
         accept = 1'b0;
      end
      if (rd_en && empty_q) begin
         underflow_d = 1'b1;
      end else begin
         underflow_d = underflow_q;
      end
      rbin_d      = rbin_q + {{ADDR_W{1'b0}}, accept};
      rptr_gray_d = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
      wsync_bin   = PW'(gray2bin(PTR_MAX_W'(wsync_gray)));
      empty_d     = (rptr_gray_d == wsync_gray);
      level_d     = wsync_bin - rbin_d;
      rd_valid_d  = accept;
   end

   // Read-domain state; async reset also discards any read still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rbin_q      <= {PW{1'b0}};
         rptr_gray_q <= {PW{1'b0}};
         level_q     <= {PW{1'b0}};
         empty_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         rbin_q      <= rbin_d;
         rptr_gray_q <= rptr_gray_d;
         level_q     <= level_d;
         empty_q     <= empty_d;
         rd_valid_q  <= rd_valid_d;
         underflow_q <= underflow_d;
      end
   end

`ifdef CDC_FIFO_ALMOST_EMPTY_EN
   logic ae_q, ae_d;

   // Threshold compare on the same next-state level that feeds the level register.
   always_comb begin
      ae_d = (PTR_MAX_W'(level_d) <= $unsigned(AE_THRESH));
   end

   // Almost-empty register starts set because the FIFO is empty out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ae_q <= 1'b1;
      end else begin
         ae_q <= ae_d;
      end
   end

   assign almost_empty = ae_q;
`else
   // Almost-empty flag not built in this configuration.
`endif

   assign rd_addr   = rbin_q[ADDR_W-1:0];
   assign rd_valid  = rd_valid_q;
   assign rptr_gray = rptr_gray_q;
   assign empty     = empty_q;
   assign level     = level_q;
   assign underflow = underflow_q;

endmodule
